// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command sequencer: command
// encodings, FSM states, ALU opcodes and small command-decode helpers.
package calc_pkg;

  localparam logic [3:0] CMD_ADD = 4'hA;
  localparam logic [3:0] CMD_SUB = 4'hB;
  localparam logic [3:0] CMD_MUL = 4'hC;
  localparam logic [3:0] CMD_CLR = 4'hD;
  localparam logic [3:0] CMD_EQ  = 4'hE;
  localparam logic [3:0] CMD_NOP = 4'hF;

  // Largest magnitude the 8-digit display can show.
  localparam int MAX_MAG = 99_999_999;

  typedef enum logic [2:0] {S_A, S_B, S_EXEC, S_SHOW, S_ERR} state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10
  } alu_op_t;

  typedef enum logic [2:0] {K_DIGIT, K_OP, K_CLR, K_EQ, K_NOP} cmd_kind_t;

  // Classify a raw keypad command.
  function automatic cmd_kind_t cmd_kind(input logic [3:0] c);
    cmd_kind_t k;
    k = K_NOP;
    if (c <= 4'd9) begin
      k = K_DIGIT;
    end else begin
      case (c)
        CMD_ADD, CMD_SUB, CMD_MUL: k = K_OP;
        CMD_CLR:                   k = K_CLR;
        CMD_EQ:                    k = K_EQ;
        default:                   k = K_NOP;
      endcase
    end
    return k;
  endfunction

  // Map an operator key onto the ALU opcode.
  function automatic alu_op_t cmd_to_op(input logic [3:0] c);
    alu_op_t o;
    case (c)
      CMD_SUB: o = ALU_SUB;
      CMD_MUL: o = ALU_MUL;
      default: o = ALU_ADD;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Decimal operand accumulator: builds a value one digit at a time
// (X*10 + d) up to MAX_DIGITS digits, with clear and parallel load.
// next_value exposes the value the register takes at the next edge so the
// parent can register its display in the same cycle.
module calc_digit_acc #(
  parameter int DATA_W     = 28,
  parameter int MAX_DIGITS = 8,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_value,
  input  logic              digit_en,
  input  logic [3:0]        digit,
  output logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] next_value,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] base_v;
  logic [CNT_W-1:0]  base_c;
  logic [CNT_W-1:0]  next_count;

  // Next value: clear first, then either load or append one digit.
  // clear together with digit_en restarts the operand with that digit.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    base_v     = clear ? '0 : value;
    base_c     = clear ? '0 : count;
    next_value = base_v;
    next_count = base_c;
    if (load) begin
      // A loaded result is treated as a complete operand.
      next_value = load_value;
      next_count = CNT_W'(MAX_DIGITS);
    end else if (digit_en && (base_c < CNT_W'(MAX_DIGITS))) begin
      next_value = (base_v << 3) + (base_v << 1) + DATA_W'(digit);
      next_count = base_c + 1'b1;
    end
  end

  // Accumulator and digit-count registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
      count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      value <= next_value;
      count <= next_count;
    end
  end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Keypad command sequencer: builds operands A and B digit by digit,
// launches the ALU over a start/done handshake with a timeout, chains
// operators, and drives the registered display value and flags.
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W      = 28,
  parameter int MAX_DIGITS  = 8,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic              alu_start,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_err,
  output logic [DATA_W-1:0] disp_value,
  output logic              disp_is_result,
  output logic              err_flag
);

  localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam int TCNT_W = $clog2(ALU_TIMEOUT);

  state_t            state;
  alu_op_t           op_q;
  alu_op_t           pend_op;
  logic              pend_valid;
  logic [TCNT_W-1:0] tcnt;

  logic              accept;
  cmd_kind_t         kind;
  alu_op_t           new_op;
  logic              do_clr;
  logic              exec_ok;
  logic              launch;

  logic              a_clear, a_load, a_den;
  logic              b_clear, b_den;
  logic [DATA_W-1:0] a_value, a_next;
  logic [DATA_W-1:0] b_value, b_next;
  logic [CNT_W-1:0]  a_count, b_count;

  assign accept  = cmd_valid && cmd_ready;
  assign kind    = cmd_kind(cmd);
  assign new_op  = cmd_to_op(cmd);
  // cmd_ready is low in S_EXEC, so CLR is honoured everywhere else.
  assign do_clr  = accept && (kind == K_CLR);
  assign exec_ok = (state == S_EXEC) && alu_done && !alu_err;
  // An operator or EQ after at least one B digit launches the ALU.
  assign launch  = accept && (state == S_B) && (b_count != '0) &&
                   ((kind == K_OP) || (kind == K_EQ));

  // Accumulator controls decoded from the current state and command.
  always_comb begin
    a_clear = do_clr;
    b_clear = do_clr;
    a_load  = exec_ok;
    a_den   = 1'b0;
    b_den   = 1'b0;
    if (accept && (kind == K_DIGIT)) begin
      a_den = (state == S_A) || (state == S_SHOW);
      b_den = (state == S_B);
      if (state == S_SHOW) a_clear = 1'b1;
    end
    if (accept && (kind == K_OP) && ((state == S_A) || (state == S_SHOW)))
      b_clear = 1'b1;
    if (exec_ok && pend_valid)
      b_clear = 1'b1;
  end

  calc_digit_acc #(
    .DATA_W    (DATA_W),
    .MAX_DIGITS(MAX_DIGITS),
    .CNT_W     (CNT_W)
  ) u_acc_a (
    .clock     (clock),
    .reset     (reset),
    .clear     (a_clear),
    .load      (a_load),
    .load_value(alu_result),
    .digit_en  (a_den),
    .digit     (cmd),
    .value     (a_value),
    .next_value(a_next),
    .count     (a_count)
  );

  calc_digit_acc #(
    .DATA_W    (DATA_W),
    .MAX_DIGITS(MAX_DIGITS),
    .CNT_W     (CNT_W)
  ) u_acc_b (
    .clock     (clock),
    .reset     (reset),
    .clear     (b_clear),
    .load      (1'b0),
    .load_value('0),
    .digit_en  (b_den),
    .digit     (cmd),
    .value     (b_value),
    .next_value(b_next),
    .count     (b_count)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_A;
      op_q           <= ALU_ADD;
      pend_op        <= ALU_ADD;
      pend_valid     <= 1'b0;
      tcnt           <= '0;
      cmd_ready      <= 1'b1;
      alu_start      <= 1'b0;
      alu_op         <= 2'b00;
      alu_a          <= '0;
      alu_b          <= '0;
      disp_value     <= '0;
      disp_is_result <= 1'b0;
      err_flag       <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      if (do_clr) begin
        state          <= S_A;
        op_q           <= ALU_ADD;
        pend_valid     <= 1'b0;
        tcnt           <= '0;
        cmd_ready      <= 1'b1;
        alu_op         <= 2'b00;
        alu_a          <= '0;
        alu_b          <= '0;
        disp_value     <= '0;
        disp_is_result <= 1'b0;
        err_flag       <= 1'b0;
      end else begin
        case (state)
          S_A: begin
            if (accept) begin
              case (kind)
                K_DIGIT: begin
                  if (a_count < CNT_W'(MAX_DIGITS)) begin
                    disp_value     <= a_next;
                    disp_is_result <= 1'b0;
                  end
                end
                K_OP: begin
                  op_q  <= new_op;
                  state <= S_B;
                end
                K_EQ: begin
                  disp_value     <= a_value;
                  disp_is_result <= 1'b1;
                  state          <= S_SHOW;
                end
                default: ;
              endcase
            end
          end

          S_B: begin
            if (accept) begin
              case (kind)
                K_DIGIT: begin
                  if (b_count < CNT_W'(MAX_DIGITS)) begin
                    disp_value     <= b_next;
                    disp_is_result <= 1'b0;
                  end
                end
                K_OP: begin
                  if (b_count == '0) begin
                    op_q <= new_op;
                  end else begin
                    pend_op    <= new_op;
                    pend_valid <= 1'b1;
                  end
                end
                K_EQ: begin
                  if (b_count != '0) pend_valid <= 1'b0;
                end
                default: ;
              endcase
            end
            if (launch) begin
              state     <= S_EXEC;
              alu_start <= 1'b1;
              alu_op    <= op_q;
              alu_a     <= a_value;
              alu_b     <= b_value;
              cmd_ready <= 1'b0;
              tcnt      <= '0;
            end
          end

          S_EXEC: begin
            if (alu_done && !alu_err) begin
              disp_value     <= alu_result;
              disp_is_result <= 1'b1;
              cmd_ready      <= 1'b1;
              if (pend_valid) begin
                op_q       <= pend_op;
                pend_valid <= 1'b0;
                state      <= S_B;
              end else begin
                state <= S_SHOW;
              end
            end else if (alu_done || (tcnt == TCNT_W'(ALU_TIMEOUT - 1))) begin
              state          <= S_ERR;
              err_flag       <= 1'b1;
              disp_value     <= '0;
              disp_is_result <= 1'b0;
              cmd_ready      <= 1'b1;
              pend_valid     <= 1'b0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end

          S_SHOW: begin
            if (accept) begin
              case (kind)
                K_DIGIT: begin
                  disp_value     <= a_next;
                  disp_is_result <= 1'b0;
                  state          <= S_A;
                end
                K_OP: begin
                  op_q  <= new_op;
                  state <= S_B;
                end
                default: ;
              endcase
            end
          end

          S_ERR: ;

          default: state <= S_A;
        endcase
      end
    end
  end

endmodule
